// File: rtl/cpcs_tx_sched_pkg.sv
// Shared constants and state encoding for the CorePCS transmit symbol scheduler.
package cpcs_tx_sched_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam int ENC_LAT = 3;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_INIT     = 2'd1,
    ST_RUN      = 2'd2,
    ST_ALIGN    = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cpcs_tx_align_timer.sv
// Counts RUN cycles and raises align_pending once every ALIGN_PERIOD of them.
module cpcs_tx_align_timer #(
  parameter int ALIGN_PERIOD = 1024,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  input  logic ack,
  output logic pending
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ALIGN_PERIOD - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             pending_reg;

  // A new period starting wins over a late acknowledge of the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
    end else if (clr) begin
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (run) begin
        if (cnt_reg == LAST) cnt_reg <= '0;
        else                 cnt_reg <= cnt_reg + 1'b1;
      end
      if (run && cnt_reg == LAST) pending_reg <= 1'b1;
      else if (ack)               pending_reg <= 1'b0;
    end
  end

  assign pending = pending_reg;

endmodule

// File: rtl/cpcs_tx_sched.sv
// Transmit symbol scheduler feeding the 8b/10b encoder: user data, idle pairs, comma bursts.
// Optional counters DATA_CNT/ALIGN_CNT are built when CPCS_TX_SCHED_STATS_EN is defined.
module cpcs_tx_sched
  import cpcs_tx_sched_pkg::*;
#(
  parameter int ALIGN_PERIOD = 1024,
  parameter int ALIGN_BURST  = 4,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  tx_data,
  input  logic        tx_k,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  enc_d,
  output logic        enc_k,
  output logic        enc_force_disp,
  output logic        enc_disp_sel,
  input  logic        enc_invalid_k,
  input  logic        k_err_clr,
  output logic [7:0]  k_err_cnt,
  output logic        align_active
`ifdef CPCS_TX_SCHED_STATS_EN
  ,
  output logic [31:0] data_cnt,
  output logic [15:0] align_cnt
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(ALIGN_BURST - 1);

  state_t     state_reg;
  logic       pair_second_reg;
  logic [3:0] burst_cnt_reg;
  logic       align_pending;
  logic       init_start;
  logic       align_start;
  logic       burst_end;
  logic       align_ack;

  // burst_cnt_reg holds the index of the burst symbol emitted at the next edge.
  always_comb begin
    init_start  = 1'b0;
    align_start = 1'b0;
    burst_end   = 1'b0;
    case (state_reg)
      ST_DISABLED:       init_start  = ~pair_second_reg & en;
      ST_RUN:            align_start = ~pair_second_reg & en & align_pending;
      ST_INIT, ST_ALIGN: burst_end   = (burst_cnt_reg == LAST_IDX);
      default:           ;
    endcase
  end

  assign align_ack = ((state_reg == ST_ALIGN) & burst_end) | (align_start & (ALIGN_BURST == 1));
  assign tx_ready  = (state_reg == ST_RUN) & ~pair_second_reg & ~align_pending & en;

  cpcs_tx_align_timer #(
    .ALIGN_PERIOD(ALIGN_PERIOD),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_reg == ST_RUN),
    .clr    (init_start),
    .ack    (align_ack),
    .pending(align_pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_DISABLED;
      pair_second_reg <= 1'b0;
      burst_cnt_reg   <= '0;
      enc_d           <= K28_5;
      enc_k           <= 1'b1;
      enc_force_disp  <= 1'b0;
      enc_disp_sel    <= 1'b0;
      align_active    <= 1'b0;
    end else begin
      enc_d          <= K28_5;
      enc_k          <= 1'b1;
      enc_force_disp <= 1'b0;
      enc_disp_sel   <= 1'b0;
      align_active   <= 1'b0;
      if (pair_second_reg) begin
        // Second half of an idle pair is unconditional.
        enc_d           <= D16_2;
        enc_k           <= 1'b0;
        pair_second_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_DISABLED: begin
            if (en) begin
              enc_force_disp <= 1'b1;
              align_active   <= 1'b1;
              burst_cnt_reg  <= 4'd1;
              state_reg      <= (ALIGN_BURST == 1) ? ST_RUN : ST_INIT;
            end else begin
              pair_second_reg <= 1'b1;
            end
          end
          ST_INIT, ST_ALIGN: begin
            align_active  <= 1'b1;
            burst_cnt_reg <= burst_cnt_reg + 4'd1;
            if (burst_end) state_reg <= en ? ST_RUN : ST_DISABLED;
          end
          ST_RUN: begin
            if (!en) begin
              state_reg       <= ST_DISABLED;
              pair_second_reg <= 1'b1;
            end else if (align_pending) begin
              align_active  <= 1'b1;
              burst_cnt_reg <= 4'd1;
              if (ALIGN_BURST != 1) state_reg <= ST_ALIGN;
            end else if (tx_valid) begin
              enc_d <= tx_data;
              enc_k <= tx_k;
            end else begin
              pair_second_reg <= 1'b1;
            end
          end
          default: state_reg <= ST_DISABLED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              k_err_cnt <= '0;
    else if (k_err_clr)      k_err_cnt <= '0;
    else if (enc_invalid_k)  k_err_cnt <= sat_inc8(k_err_cnt);
  end

`ifdef CPCS_TX_SCHED_STATS_EN
  logic handshake;
  assign handshake = tx_valid & tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_cnt  <= '0;
      align_cnt <= '0;
    end else if (k_err_clr) begin
      data_cnt  <= '0;
      align_cnt <= '0;
    end else begin
      if (handshake) data_cnt <= data_cnt + 32'd1;
      if (align_ack && align_cnt != 16'hFFFF) align_cnt <= align_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpcs_tx_sched.sv
// Self-checking bench for cpcs_tx_sched: vector table for start-up, scoreboard for streaming.
module tb_cpcs_tx_sched;
  import cpcs_tx_sched_pkg::*;

  localparam int ALIGN_PERIOD = 1024;
  localparam int ALIGN_BURST  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_k = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] enc_d;
  logic       enc_k;
  logic       enc_force_disp;
  logic       enc_disp_sel;
  logic       enc_invalid_k = 1'b0;
  logic       k_err_clr = 1'b0;
  logic [7:0] k_err_cnt;
  logic       align_active;
`ifdef CPCS_TX_SCHED_STATS_EN
  logic [31:0] data_cnt;
  logic [15:0] align_cnt;
`endif

  always #5 clk = ~clk;

  cpcs_tx_sched #(
    .ALIGN_PERIOD(ALIGN_PERIOD),
    .ALIGN_BURST (ALIGN_BURST),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .tx_data       (tx_data),
    .tx_k          (tx_k),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .enc_d         (enc_d),
    .enc_k         (enc_k),
    .enc_force_disp(enc_force_disp),
    .enc_disp_sel  (enc_disp_sel),
    .enc_invalid_k (enc_invalid_k),
    .k_err_clr     (k_err_clr),
    .k_err_cnt     (k_err_cnt),
    .align_active  (align_active)
`ifdef CPCS_TX_SCHED_STATS_EN
    ,
    .data_cnt      (data_cnt),
    .align_cnt     (align_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       en;
    logic       valid;
    logic [7:0] data;
    logic       k;
    logic       exp_rdy;
    logic [7:0] exp_d;
    logic       exp_k;
    logic       exp_fd;
    logic       exp_aa;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];
  logic [8:0] sb[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       hs;
    logic [8:0] exp_sym;
    logic [8:0] prev_sym;
    logic [3:0] nib;
    int n_burst, blen, gap_cnt, done, got, bad, kexp;

    // en, valid, data, k | ready, d, k, force_disp, align_active
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'hBC, 1'b1, 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enc", {enc_force_disp, enc_disp_sel, align_active, enc_k, enc_d}, {1'b0, 1'b0, 1'b0, 1'b1, 8'hBC});
    chk("rst_ready", tx_ready, 1'b0);
    chk("rst_kerr", k_err_cnt, 8'd0);
    rst_n = 1'b1;

    // Start-up INIT burst, idle pairs and handshake placement
    for (int i = 0; i < NV; i++) begin
      en = vecs[i].en; tx_valid = vecs[i].valid; tx_data = vecs[i].data; tx_k = vecs[i].k;
      #1;
      chk($sformatf("v%0d_ready", i), tx_ready, vecs[i].exp_rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_sym", i), {enc_force_disp, enc_disp_sel, align_active, enc_k, enc_d},
          {vecs[i].exp_fd, 1'b0, vecs[i].exp_aa, vecs[i].exp_k, vecs[i].exp_d});
    end

    // Continuous user stream 00..0F through two alignment bursts
    nib = 4'h0; n_burst = 0; blen = 0; gap_cnt = 0; done = 0;
    for (int c = 0; c < 4000 && done == 0; c++) begin
      tx_valid = 1'b1; tx_data = {4'h0, nib}; tx_k = 1'b0;
      #1;
      hs = tx_ready;
      if (hs) begin
        sb.push_back({1'b0, 4'h0, nib});
        nib = nib + 4'h1;
      end
      @(posedge clk); #1;
      if (hs) begin
        exp_sym = sb.pop_front();
        chk("stream_sym", {align_active, enc_k, enc_d}, {1'b0, exp_sym});
        if (blen != 0) chk("burst_len", blen, ALIGN_BURST);
        blen = 0;
        gap_cnt++;
      end else begin
        chk("burst_sym", {align_active, enc_k, enc_d}, {1'b1, 1'b1, 8'hBC});
        if (blen == 0) begin
          n_burst++;
          // Each period has one RUN cycle with align_pending up, so one byte fewer than the period.
          if (n_burst == 2) chk("data_gap", gap_cnt, ALIGN_PERIOD - 1);
          gap_cnt = 0;
        end
        blen++;
        if (n_burst == 2 && blen == ALIGN_BURST) done = 1;
      end
    end
    chk("stream_done", done, 1);
    chk("sb_empty", sb.size(), 0);

    // Idle-only period: the pending burst must wait for the D16.2 half of the pair
    tx_valid = 1'b0;
    gap_cnt = 0; got = 0; bad = 0; prev_sym = '0;
    for (int c = 0; c < 3000 && got == 0; c++) begin
      @(posedge clk); #1;
      if (align_active) begin
        got = 1;
      end else begin
        if ({enc_k, enc_d} !== (((gap_cnt % 2) == 0) ? {1'b1, 8'hBC} : {1'b0, 8'h50})) bad++;
        prev_sym = {enc_k, enc_d};
        gap_cnt++;
      end
    end
    chk("idle_burst_seen", got, 1);
    chk("idle_pairs", bad, 0);
    chk("idle_last", prev_sym, {1'b0, 8'h50});
    chk("idle_gap", gap_cnt, ALIGN_PERIOD);

    // EN dropped on the first ALIGN symbol: burst completes, then DISABLED idles
    en = 1'b0;
    for (int i = 1; i < ALIGN_BURST; i++) begin
      #1;
      chk("endrop_ready", tx_ready, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("endrop_burst%0d", i), {align_active, enc_k, enc_d}, {1'b1, 1'b1, 8'hBC});
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("dis_idle%0d", i), {tx_ready, align_active, enc_k, enc_d},
          (i % 2 == 0) ? {1'b0, 1'b0, 1'b1, 8'hBC} : {1'b0, 1'b0, 1'b0, 8'h50});
    end

    // Re-enable re-runs INIT with a forced RD-
    en = 1'b1;
    @(posedge clk); #1;
    chk("reinit_first", {enc_force_disp, enc_disp_sel, align_active, enc_k, enc_d}, {1'b1, 1'b0, 1'b1, 1'b1, 8'hBC});
    @(posedge clk); #1;
    chk("reinit_second", {enc_force_disp, align_active, enc_k, enc_d}, {1'b0, 1'b1, 1'b1, 8'hBC});

    // Asynchronous reset in the middle of INIT
    #1;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("async_rst_enc", {enc_force_disp, align_active, enc_k, enc_d}, {1'b0, 1'b0, 1'b1, 8'hBC});
    chk("async_rst_ready", tx_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Invalid-K counter: 300 pulses saturate at 255
    kexp = 0;
    for (int i = 0; i < 300; i++) begin
      enc_invalid_k = 1'b1;
      @(posedge clk); #1;
      enc_invalid_k = 1'b0;
      kexp = (kexp < 255) ? kexp + 1 : 255;
      if (i == 99) chk("kerr_100", k_err_cnt, kexp);
      @(posedge clk); #1;
    end
    chk("kerr_sat", k_err_cnt, 8'd255);
    k_err_clr = 1'b1; enc_invalid_k = 1'b1;
    @(posedge clk); #1;
    k_err_clr = 1'b0; enc_invalid_k = 1'b0;
    chk("kerr_clr_prio", k_err_cnt, 8'd0);
    repeat (3) begin
      enc_invalid_k = 1'b1;
      @(posedge clk); #1;
    end
    enc_invalid_k = 1'b0;
    chk("kerr_after_clr", k_err_cnt, 8'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
